// File: rtl/i2c_bus_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module   : i2c_bus_conditioner_if
// Purpose  : Pin-side and conditioned-side signal bundle of the I2C bus
//            conditioner. "slave" is the conditioner's view, "master" is the
//            view of whatever drives the raw pins and consumes the results.
// Revision : 1.0 - initial release
// ============================================================================
interface i2c_bus_conditioner_if;
  logic i_scl;       // raw SCL pin, asynchronous
  logic i_sda;       // raw SDA pin (read side), asynchronous
  logic o_scl;       // conditioned SCL level
  logic o_sda;       // conditioned SDA level
  logic o_scl_rise;  // accepted SCL 0->1
  logic o_scl_fall;  // accepted SCL 1->0
  logic o_start;     // START / repeated START
  logic o_stop;      // STOP
  logic o_busy;      // bus owned between START and STOP/timeout
  logic o_timeout;   // SCL held low too long while busy

  modport slave (
    input  i_scl, i_sda,
    output o_scl, o_sda, o_scl_rise, o_scl_fall,
           o_start, o_stop, o_busy, o_timeout
  );

  modport master (
    output i_scl, i_sda,
    input  o_scl, o_sda, o_scl_rise, o_scl_fall,
           o_start, o_stop, o_busy, o_timeout
  );
endinterface
`default_nettype wire

// File: rtl/i2c_bus_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : i2c_bus_conditioner
// Purpose  : Synchronizes and glitch-filters raw I2C SCL/SDA, then derives
//            edge strobes, START/STOP detection, bus-busy state and an
//            SCL-low timeout.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_bus_conditioner #(
  parameter int SYNC_STAGES    = 2,
  parameter int GLITCH_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input wire i_clk,
  input wire i_rst,
  i2c_bus_conditioner_if.slave bus
);

  // Filter counter value at which the next differing cycle is the accepting one.
  localparam logic [7:0]  c_glitch_last  = 8'(GLITCH_CYCLES - 1);
  // Timeout counter value at which the next busy/SCL-low cycle expires the bus.
  localparam logic [23:0] c_timeout_last = 24'(TIMEOUT_CYCLES - 1);

  // Line index 0 is SCL, line index 1 is SDA.
  logic [1:0] w_raw;
  logic [1:0] w_filt;

  assign w_raw = {bus.i_sda, bus.i_scl};

  // --------------------------------------------------------------------------
  // Per-line synchronizer and glitch filter. The filter only accepts a new
  // level once the synchronized level has disagreed with the accepted level
  // for GLITCH_CYCLES consecutive cycles; any agreement restarts the count.
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_line
    logic [SYNC_STAGES-1:0] r_sync;
    logic [7:0]             r_cnt;
    logic                   r_filt;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Metastability chain; idles high like a released open-drain line.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_sync <= '1;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[gi]};
      end
    end

    // Persistence filter: toggle on the cycle the disagreement count completes.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_cnt  <= '0;
        r_filt <= 1'b1;
      end else if (w_sync == r_filt) begin
        r_cnt  <= '0;
      end else if (r_cnt >= c_glitch_last) begin
        r_filt <= ~r_filt;
        r_cnt  <= '0;
      end else if (r_cnt != 8'hFF) begin
        r_cnt  <= r_cnt + 8'd1;
      end
    end

    assign w_filt[gi] = r_filt;
  end

  // --------------------------------------------------------------------------
  // Output stage. r_scl/r_sda are the published levels; comparing them with
  // the filter outputs lets every strobe be registered in the same cycle the
  // published level takes its new value.
  // --------------------------------------------------------------------------
  logic        r_scl;
  logic        r_sda;
  logic        r_scl_rise;
  logic        r_scl_fall;
  logic        r_start;
  logic        r_stop;
  logic        r_busy;
  logic        r_timeout;
  logic [23:0] r_to_cnt;

  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;
  logic w_busy_scl_low;
  logic w_to_hit;

  assign w_scl_rise = w_filt[0] & ~r_scl;
  assign w_scl_fall = ~w_filt[0] & r_scl;
  // START/STOP need SCL high now and in the previous cycle, which also rules
  // out a simultaneous SCL change.
  assign w_start    = r_scl & w_filt[0] & r_sda & ~w_filt[1];
  assign w_stop     = r_scl & w_filt[0] & ~r_sda & w_filt[1];

  assign w_busy_scl_low = r_busy & ~r_scl;
  // A START in the same cycle takes priority over an expiring timeout.
  assign w_to_hit       = w_busy_scl_low & ~w_start & (r_to_cnt >= c_timeout_last);

  // Published levels and edge/condition strobes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_scl      <= 1'b1;
      r_sda      <= 1'b1;
      r_scl_rise <= 1'b0;
      r_scl_fall <= 1'b0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
    end else begin
      r_scl      <= w_filt[0];
      r_sda      <= w_filt[1];
      r_scl_rise <= w_scl_rise;
      r_scl_fall <= w_scl_fall;
      r_start    <= w_start;
      r_stop     <= w_stop;
    end
  end

  // Busy tracking and SCL-low timeout; busy reacts one cycle after its strobe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_to_cnt  <= '0;
    end else begin
      r_timeout <= w_to_hit;

      if (r_start) begin
        r_busy <= 1'b1;
      end else if (r_stop || r_timeout) begin
        r_busy <= 1'b0;
      end

      if (!w_busy_scl_low || w_start || w_to_hit) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt != 24'hFF_FFFF) begin
        r_to_cnt <= r_to_cnt + 24'd1;
      end
    end
  end

  assign bus.o_scl      = r_scl;
  assign bus.o_sda      = r_sda;
  assign bus.o_scl_rise = r_scl_rise;
  assign bus.o_scl_fall = r_scl_fall;
  assign bus.o_start    = r_start;
  assign bus.o_stop     = r_stop;
  assign bus.o_busy     = r_busy;
  assign bus.o_timeout  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_i2c_bus_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_bus_conditioner
// Purpose  : Self-checking bench for i2c_bus_conditioner: directed scenarios
//            with literal expectations plus randomized pin activity compared
//            every cycle against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_bus_conditioner;

  localparam int N = 2;    // synchronizer depth
  localparam int G = 4;    // glitch persistence
  localparam int T = 100;  // timeout length

  logic clk = 1'b0;
  logic rst = 1'b1;

  i2c_bus_conditioner_if bus();

  i2c_bus_conditioner #(
    .SYNC_STAGES    (N),
    .GLITCH_CYCLES  (G),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Strobe tallies gathered by the compare process.
  int c_rise = 0, c_fall = 0, c_start = 0, c_stop = 0, c_to = 0, c_scl_low = 0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model. Each line keeps the recent raw samples (delay line of
  // synchronizer depth) and a window of the last G synchronized values; a new
  // level is accepted when the whole window disagrees with the accepted level.
  // Published levels trail acceptance by one cycle.
  // --------------------------------------------------------------------------
  bit m_hist[2][$];
  bit m_win[2][$];
  bit m_filt[2];
  bit e_out[2];
  bit e_rise, e_fall, e_start, e_stop, e_busy, e_to;
  int m_low;

  function automatic void model_reset();
    for (int l = 0; l < 2; l++) begin
      m_hist[l].delete();
      m_win[l].delete();
      repeat (N) m_hist[l].push_back(1'b1);
      repeat (G) m_win[l].push_back(1'b1);
      m_filt[l] = 1'b1;
      e_out[l]  = 1'b1;
    end
    e_rise = 0; e_fall = 0; e_start = 0; e_stop = 0; e_busy = 0; e_to = 0;
    m_low  = 0;
  endfunction

  function automatic void model_step(input bit raw_scl, input bit raw_sda);
    bit raw[2];
    bit nout[2];
    bit s, all_diff;
    bit n_start, n_stop, n_busy, n_to;
    raw[0] = raw_scl;
    raw[1] = raw_sda;
    for (int l = 0; l < 2; l++) begin
      s = m_hist[l][0];
      m_hist[l].push_back(raw[l]);
      void'(m_hist[l].pop_front());
      nout[l] = m_filt[l];
      m_win[l].push_back(s);
      if (m_win[l].size() > G) void'(m_win[l].pop_front());
      all_diff = 1'b1;
      for (int k = 0; k < m_win[l].size(); k++)
        if (m_win[l][k] == m_filt[l]) all_diff = 1'b0;
      if (all_diff) m_filt[l] = ~m_filt[l];
    end
    n_start = e_out[0] & nout[0] & e_out[1] & ~nout[1];
    n_stop  = e_out[0] & nout[0] & ~e_out[1] & nout[1];
    if (e_start) n_busy = 1'b1;
    else if (e_stop || e_to) n_busy = 1'b0;
    else n_busy = e_busy;
    n_to = 1'b0;
    if (e_busy && !e_out[0] && !n_start) begin
      m_low++;
      if (m_low >= T) begin
        n_to  = 1'b1;
        m_low = 0;
      end
    end else begin
      m_low = 0;
    end
    e_rise  = nout[0] & ~e_out[0];
    e_fall  = ~nout[0] & e_out[0];
    e_start = n_start;
    e_stop  = n_stop;
    e_busy  = n_busy;
    e_to    = n_to;
    e_out[0] = nout[0];
    e_out[1] = nout[1];
  endfunction

  // Compare process: advance the model on each rising edge, check on the falling edge.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (rst) model_reset();
      else model_step(bus.i_scl, bus.i_sda);
      @(negedge clk);
      if (rst) model_reset();
      check_bit("o_scl",      bus.o_scl,      e_out[0]);
      check_bit("o_sda",      bus.o_sda,      e_out[1]);
      check_bit("o_scl_rise", bus.o_scl_rise, e_rise);
      check_bit("o_scl_fall", bus.o_scl_fall, e_fall);
      check_bit("o_start",    bus.o_start,    e_start);
      check_bit("o_stop",     bus.o_stop,     e_stop);
      check_bit("o_busy",     bus.o_busy,     e_busy);
      check_bit("o_timeout",  bus.o_timeout,  e_to);
      c_rise    += int'(bus.o_scl_rise);
      c_fall    += int'(bus.o_scl_fall);
      c_start   += int'(bus.o_start);
      c_stop    += int'(bus.o_stop);
      c_to      += int'(bus.o_timeout);
      c_scl_low += int'(!bus.o_scl);
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int lat;
  int s_rise, s_fall, s_start, s_stop, s_to, s_low;

  task automatic snap();
    s_rise = c_rise; s_fall = c_fall; s_start = c_start;
    s_stop = c_stop; s_to = c_to; s_low = c_scl_low;
  endtask

  // Directed scenarios followed by randomized activity.
  initial begin
    bus.i_scl = 1'b1;
    bus.i_sda = 1'b1;
    rst       = 1'b1;
    wait_cycles(3);
    check_bit("reset_scl",   bus.o_scl,   1'b1);
    check_bit("reset_sda",   bus.o_sda,   1'b1);
    check_bit("reset_busy",  bus.o_busy,  1'b0);
    check_bit("reset_start", bus.o_start, 1'b0);
    rst = 1'b0;
    wait_cycles(10);

    // START latency from the first sampling edge.
    bus.i_sda = 1'b0;
    @(posedge clk);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      wait_cycles(1);
      if (bus.o_sda === 1'b0) begin
        lat = i;
        break;
      end
    end
    check_int("start_latency", lat, 6);
    check_bit("start_strobe", bus.o_start, 1'b1);
    wait_cycles(1);
    check_bit("busy_after_start", bus.o_busy, 1'b1);
    check_bit("start_one_cycle", bus.o_start, 1'b0);

    // Eight SCL clocks, SDA changing only while SCL is low.
    snap();
    for (int k = 0; k < 8; k++) begin
      bus.i_scl = 1'b0;
      wait_cycles(8);
      bus.i_sda = 1'($urandom_range(0, 1));
      wait_cycles(8);
      bus.i_scl = 1'b1;
      wait_cycles(12);
    end
    wait_cycles(10);
    check_int("clk8_rise",  c_rise - s_rise, 8);
    check_int("clk8_fall",  c_fall - s_fall, 8);
    check_int("clk8_start", c_start - s_start, 0);
    check_int("clk8_stop",  c_stop - s_stop, 0);

    // STOP ends the transaction.
    bus.i_scl = 1'b0; wait_cycles(8);
    bus.i_sda = 1'b0; wait_cycles(8);
    bus.i_scl = 1'b1; wait_cycles(12);
    snap();
    bus.i_sda = 1'b1; wait_cycles(12);
    check_int("stop_count", c_stop - s_stop, 1);
    check_bit("stop_busy", bus.o_busy, 1'b0);

    // Three-cycle SCL glitch is rejected entirely.
    snap();
    bus.i_scl = 1'b0; wait_cycles(3);
    bus.i_scl = 1'b1; wait_cycles(15);
    check_int("glitch_strobes", (c_rise - s_rise) + (c_fall - s_fall) +
              (c_start - s_start) + (c_stop - s_stop) + (c_to - s_to), 0);
    check_int("glitch_scl_low", c_scl_low - s_low, 0);

    // Three-cycle SDA glitch while SCL high: no START.
    snap();
    bus.i_sda = 1'b0; wait_cycles(3);
    bus.i_sda = 1'b1; wait_cycles(15);
    check_int("sda_glitch_start", c_start - s_start, 0);

    // Four-cycle SCL pulse is just long enough to be accepted.
    snap();
    bus.i_scl = 1'b0; wait_cycles(4);
    bus.i_scl = 1'b1; wait_cycles(15);
    check_int("pulse4_fall", c_fall - s_fall, 1);
    check_int("pulse4_rise", c_rise - s_rise, 1);

    // SCL and SDA fall together: SCL edge only.
    snap();
    bus.i_scl = 1'b0;
    bus.i_sda = 1'b0;
    wait_cycles(12);
    check_int("simul_fall",  c_fall - s_fall, 1);
    check_int("simul_start", c_start - s_start, 0);
    bus.i_scl = 1'b1; wait_cycles(12);
    // STOP while idle still strobes, busy stays low.
    snap();
    bus.i_sda = 1'b1; wait_cycles(12);
    check_int("idle_stop", c_stop - s_stop, 1);
    check_bit("idle_stop_busy", bus.o_busy, 1'b0);

    // SCL-low timeout on a busy bus.
    bus.i_sda = 1'b0; wait_cycles(12);
    check_bit("to_busy", bus.o_busy, 1'b1);
    snap();
    bus.i_scl = 1'b0;
    for (int i = 0; i < 20; i++) begin
      wait_cycles(1);
      if (bus.o_scl === 1'b0) break;
    end
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      wait_cycles(1);
      if (bus.o_timeout === 1'b1) begin
        lat = i;
        break;
      end
    end
    check_int("to_latency", lat, T);
    wait_cycles(1);
    check_bit("to_busy_clear", bus.o_busy, 1'b0);
    wait_cycles(20);
    check_int("to_once", c_to - s_to, 1);
    bus.i_scl = 1'b1; wait_cycles(12);
    bus.i_sda = 1'b1; wait_cycles(12);

    // Randomized pin activity, including short glitches and long SCL holds.
    for (int seg = 0; seg < 350; seg++) begin
      int ch, len;
      ch  = int'($urandom_range(0, 9));
      len = ($urandom_range(0, 39) == 0) ? int'($urandom_range(100, 130))
                                         : int'($urandom_range(1, 12));
      case (ch)
        0, 1, 2, 3: bus.i_scl = ~bus.i_scl;
        4, 5, 6:    bus.i_sda = ~bus.i_sda;
        7: begin
          bus.i_scl = ~bus.i_scl;
          bus.i_sda = ~bus.i_sda;
        end
        8: begin
          bus.i_scl = ~bus.i_scl;
          wait_cycles(int'($urandom_range(1, 5)));
          bus.i_scl = ~bus.i_scl;
        end
        default: begin
          bus.i_sda = ~bus.i_sda;
          wait_cycles(int'($urandom_range(1, 5)));
          bus.i_sda = ~bus.i_sda;
        end
      endcase
      wait_cycles(len);
    end

    // Asynchronous reset during a transaction.
    bus.i_scl = 1'b1;
    bus.i_sda = 1'b1;
    wait_cycles(15);
    bus.i_sda = 1'b0;
    wait_cycles(12);
    check_bit("pre_reset_busy", bus.o_busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_bit("async_rst_busy", bus.o_busy, 1'b0);
    check_bit("async_rst_scl",  bus.o_scl,  1'b1);
    check_bit("async_rst_sda",  bus.o_sda,  1'b1);
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(1);
    check_bit("post_rst_start", bus.o_start, 1'b0);
    check_bit("post_rst_fall",  bus.o_scl_fall, 1'b0);
    check_bit("post_rst_busy",  bus.o_busy, 1'b0);
    wait_cycles(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
